// File: rtl/result_bcd_display.sv
// Binary-to-BCD converter for the miniALU result with seven-segment drive.
// One double-dabble step per clock over a scratch register that is one digit
// wider than the displayed digits, so values above the display range are
// flagged as overflow. Outputs hold their last values between conversions.
module result_bcd_display #(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5
);

  localparam int SCR_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_t                state_r, state_s;
  logic [IN_WIDTH-1:0]   bin_r, bin_s;
  logic                  blank_r, blank_s;
  logic [SCR_W-1:0]      scr_r, scr_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  done_r, done_s;
  logic                  ovf_r, ovf_s;
  logic [4*DIGITS-1:0]   bcd_r, bcd_s;
  logic [6:0]            hex_r [6];
  logic [6:0]            hex_s [6];

  logic [SCR_W-1:0]      adj_s;
  logic [SCR_W-1:0]      step_s;
  logic                  step_ovf_s;
  logic [6:0]            disp_s [6];
  logic [3:0]            dig_s;
  logic                  seen_s;

  // Double-dabble correction (+3 on digits >= 5) followed by the one-bit shift.
  always_comb begin
    adj_s = scr_r;
    for (int d = 0; d <= DIGITS; d++) begin
      if (scr_r[4*d +: 4] >= 4'd5) begin
        adj_s[4*d +: 4] = scr_r[4*d +: 4] + 4'd3;
      end else begin
        adj_s[4*d +: 4] = scr_r[4*d +: 4];
      end
    end
    step_s = {adj_s[SCR_W-2:0], bin_r[IN_WIDTH-1]};
  end

  // Segment patterns for the post-step scratch value, with dash and blanking rules.
  always_comb begin
    step_ovf_s = (step_s[SCR_W-1 -: 4] != 4'd0);
    seen_s     = 1'b0;
    dig_s      = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      if (i < DIGITS) begin
        dig_s = step_s[4*i +: 4];
      end else begin
        dig_s = 4'd0;
      end
      seen_s = seen_s | (dig_s != 4'd0);
      if (step_ovf_s) begin
        disp_s[i] = 7'h3F;
      end else if (blank_r && (i != 0) && !seen_s) begin
        disp_s[i] = 7'h7F;
      end else begin
        disp_s[i] = seg7(dig_s);
      end
    end
  end

  // Next-state and next-register logic for the IDLE/CONVERT controller.
  always_comb begin
    state_s = state_r;
    bin_s   = bin_r;
    blank_s = blank_r;
    scr_s   = scr_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    ovf_s   = ovf_r;
    bcd_s   = bcd_r;
    hex_s   = hex_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          bin_s   = bin_in;
          blank_s = blank_lz;
          scr_s   = '0;
          cnt_s   = '0;
          state_s = CONVERT;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        scr_s = step_s;
        bin_s = {bin_r[IN_WIDTH-2:0], 1'b0};
        cnt_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(IN_WIDTH - 1)) begin
          state_s = IDLE;
          done_s  = 1'b1;
          ovf_s   = step_ovf_s;
          bcd_s   = step_s[4*DIGITS-1:0];
          hex_s   = disp_s;
        end else begin
          state_s = CONVERT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      bin_r   <= '0;
      blank_r <= 1'b0;
      scr_r   <= '0;
      cnt_r   <= '0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      bcd_r   <= '0;
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= 7'h7F;
      end
    end else begin
      state_r <= state_s;
      bin_r   <= bin_s;
      blank_r <= blank_s;
      scr_r   <= scr_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
      ovf_r   <= ovf_s;
      bcd_r   <= bcd_s;
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= hex_s[i];
      end
    end
  end

  assign busy     = (state_r == CONVERT);
  assign done     = done_r;
  assign overflow = ovf_r;
  assign bcd_out  = bcd_r;
  assign hex0     = hex_r[0];
  assign hex1     = hex_r[1];
  assign hex2     = hex_r[2];
  assign hex3     = hex_r[3];
  assign hex4     = hex_r[4];
  assign hex5     = hex_r[5];

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: expected results are queued with
// their due cycle when a start is driven and compared when done fires.
module tb_result_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] bin_in;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [23:0] bcd_out;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  result_bcd_display #(.IN_WIDTH(20), .DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .blank_lz(blank_lz),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] due;
    logic [23:0] bcd;
    logic        ovf;
    logic [41:0] hex;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [41:0] hx(input logic [6:0] h5, input logic [6:0] h4,
                                     input logic [6:0] h3, input logic [6:0] h2,
                                     input logic [6:0] h1, input logic [6:0] h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  // Called at a negedge: drives start for one cycle and queues the expected result.
  task automatic start_conv(input logic [19:0] v, input logic b, input bit expect_done,
                            input logic [23:0] ebcd, input logic eovf, input logic [41:0] ehex);
    exp_t e;
    start    = 1'b1;
    bin_in   = v;
    blank_lz = b;
    if (expect_done) begin
      e.due = 32'(cyc + 21);
      e.bcd = ebcd;
      e.ovf = eovf;
      e.hex = ehex;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_ovf"},  64'(overflow), 64'd0);
    check({pfx, "_bcd"},  64'(bcd_out), 64'd0);
    check({pfx, "_hex"},  64'({hex5, hex4, hex3, hex2, hex1, hex0}),
          64'(hx(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)));
  endtask

  // Scoreboard monitor: done must fire exactly at the front entry's due cycle.
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    exp_done = (sb.size() != 0) && (sb[0].due == 32'(cyc));
    if (exp_done || done === 1'b1) begin
      check("done_timing", 64'(done), 64'(exp_done));
      if (exp_done) begin
        e = sb.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e.bcd));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    bin_in   = 20'd0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("rst");

    // 225 with blanking, started on the first edge after reset release
    rst_n = 1'b1;
    start_conv(20'd225, 1'b1, 1'b1, 24'h000225, 1'b0,
               hx(7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h24, 7'h12));
    for (int k = 0; k < 20; k++) begin
      check($sformatf("busy_conv%0d", k), 64'(busy), 64'd1);
      @(negedge clk);
    end
    check("busy_after", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    wait_idle(40);

    // zero with and without leading-zero blanking
    start_conv(20'd0, 1'b1, 1'b1, 24'h000000, 1'b0,
               hx(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));
    wait_idle(40);
    start_conv(20'd0, 1'b0, 1'b1, 24'h000000, 1'b0,
               hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));
    wait_idle(40);

    // display range limit and first overflowing value
    start_conv(20'd999999, 1'b1, 1'b1, 24'h999999, 1'b0,
               hx(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10));
    wait_idle(40);
    start_conv(20'd1000000, 1'b1, 1'b1, 24'h000000, 1'b1,
               hx(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F));
    wait_idle(40);

    // start while busy is ignored; start in the done cycle is accepted
    start_conv(20'd12345, 1'b1, 1'b1, 24'h012345, 1'b0,
               hx(7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12));
    repeat (4) @(negedge clk);
    start    = 1'b1;
    bin_in   = 20'd678;
    blank_lz = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    bin_in   = 20'hFFFFF;
    blank_lz = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    start_conv(20'd678, 1'b0, 1'b1, 24'h000678, 1'b0,
               hx(7'h40, 7'h40, 7'h40, 7'h02, 7'h78, 7'h00));
    wait_idle(40);

    // reset in the middle of a conversion aborts it
    start_conv(20'd54321, 1'b0, 1'b0, 24'h000000, 1'b0, 42'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("midrst");
    rst_n = 1'b1;
    start_conv(20'd54321, 1'b0, 1'b1, 24'h054321, 1'b0,
               hx(7'h40, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79));
    wait_idle(40);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_bcd_display.md
RESULT_BCD_DISPLAY -- requirements
Module: result_bcd_display

Interface
REQ-001 Parameter IN_WIDTH, default 20: width of the binary ALU result consumed; the design SHALL be verified at default only.
REQ-002 Parameter DIGITS, default 6: number of decimal digits/seven-segment outputs driven.
REQ-003 Port clk, input, 1: single rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: request to convert bin_in; sampled only in IDLE.
REQ-006 Port bin_in, input, IN_WIDTH: unsigned miniALU result; captured only on an accepted start.
REQ-007 Port blank_lz, input, 1: 1 = blank leading-zero digits; captured with bin_in.
REQ-008 Port busy, output, 1: high while a conversion is in progress.
REQ-009 Port done, output, 1: one-cycle pulse when new outputs are valid.
REQ-010 Port overflow, output, 1: captured value exceeds 999999.
REQ-011 Port bcd_out, output, 4*DIGITS: packed BCD of the last completed conversion; digit 0 in [3:0].
REQ-012 Ports hex0..hex5, output, 7 each: active-low segments {g,f,e,d,c,b,a}; hex0 is the least-significant digit.

Function
REQ-013 FSM states SHALL be IDLE and CONVERT only.
REQ-014 In IDLE with start=1, the block SHALL load bin_in and blank_lz into internal registers, clear a 7-digit (28-bit) BCD scratch register and the shift counter, and enter CONVERT.
REQ-015 Each CONVERT cycle SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift the scratch and binary registers left by one, moving the binary MSB into the scratch LSB.
REQ-016 After exactly IN_WIDTH steps, the same edge SHALL update bcd_out, overflow and hex0..hex5, assert done for one cycle, and return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle 20 clocks after the clock edge that accepted start.
REQ-018 busy SHALL be 1 in every CONVERT cycle and 0 in IDLE, including the done cycle.
REQ-019 start while busy=1 SHALL be ignored; bin_in and blank_lz changes during CONVERT SHALL have no effect.
REQ-020 start asserted in the done cycle SHALL be accepted, because the FSM is in IDLE.
REQ-021 overflow SHALL be 1 iff scratch digit 6 is non-zero, i.e. the value is > 999999; bcd_out SHALL then hold the low six digits.
REQ-022 When overflow=1, all hex outputs SHALL show a dash (7'h3F).
REQ-023 Segment codes SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-024 With blank_lz=1, each zero digit above the most-significant non-zero digit SHALL be driven 7'h7F. hex0 SHALL never be blanked.
REQ-025 Between conversions, bcd_out, overflow and hex outputs SHALL hold their last values.

Reset
REQ-026 While rst_n=0 at a clock edge: FSM to IDLE; busy=0, done=0, overflow=0, bcd_out=0, hex0..hex5=7'h7F; scratch, counter and captured registers cleared.
REQ-027 A reset during CONVERT SHALL abort the conversion with no done pulse. start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-028 Apply reset for 2 cycles -> busy=0, done=0, overflow=0, bcd_out=0, all hex=7'h7F.
REQ-029 Apply start for one cycle with bin_in=225, blank_lz=1 -> busy high for 20 cycles, then done pulses exactly 20 cycles after acceptance. Required outputs: bcd_out=24'h000225, hex0=12, hex1=24, hex2=24, hex3..5=7F.
REQ-030 Convert bin_in=0 with blank_lz=1, then with blank_lz=0 -> first: hex0=40, others 7F. Second: all hex=40.
REQ-031 Convert bin_in=999999 -> bcd_out=24'h999999, overflow=0. Then convert bin_in=1000000 -> overflow=1, bcd_out=24'h000000, all hex=3F.
REQ-032 Convert 12345; re-assert start with bin_in=678 five cycles in -> exactly one done, bcd_out=24'h012345. Then assert start in the done cycle with 678 -> accepted, second done 20 cycles later with bcd_out=24'h000678.
REQ-033 Drop rst_n 10 cycles into a conversion of 54321 -> no done pulse, outputs at reset values. A following start with 54321 -> bcd_out=24'h054321.
